onchip_mem_arbiter: RTL

- Shares the single-port 4096x32 on-chip RAM (byte enables, 1-cycle read latency, registered address, unregistered q) between two Avalon-MM masters.
- Uses round-robin arbitration, one access per cycle, and fully pipelined reads.
- Contains a clear sequencer that zero-fills the whole RAM on request and stalls both masters while it runs.
- Sits between the system interconnect and the RAM wrapper.

---
 rtl/onchip_mem_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 38 +++
 rtl/onchip_mem_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_pkg.sv
// onchip_mem_pkg: shared widths, FSM state encoding and master indices
// for the on-chip RAM arbiter.
`default_nettype none

package onchip_mem_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BE_W   = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int M0 = 0;
  localparam int M1 = 1;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter with a one-hot (or zero) grant.
// Revision: 1.0
`default_nettype none

module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  logic r_last_grant;

  // On a tie the master that did not win last time is served.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = r_last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
    end else if (|grant) begin
      r_last_grant <= grant[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: shares a single-port on-chip RAM between two Avalon-MM
// masters with round-robin arbitration and a zero-fill clear sequencer.
`default_nettype none

module onchip_mem_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BE_W   = DEF_BE_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_rdv0;
  logic              r_rdv1;

  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_arb_en;

  assign w_req[M0] = m0_read | m0_write;
  assign w_req[M1] = m1_read | m1_write;
  assign w_arb_en  = (r_state == IDLE);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (w_req),
    .enable  (w_arb_en),
    .grant   (w_grant)
  );

  // Grant is forced to zero during CLEAR, so every request stalls there.
  assign m0_waitrequest = w_req[M0] & ~w_grant[M0];
  assign m1_waitrequest = w_req[M1] & ~w_grant[M1];

  assign mem_clken = 1'b1;

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    if (r_state == CLEAR) begin
      mem_address    = r_cnt;
      mem_byteenable = '1;
      mem_writedata  = '0;
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
    end else if (w_grant[M1]) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
    end else if (w_grant[M0]) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
    end
  end

  // A request with both read and write set is a write and returns no data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdv0 <= 1'b0;
      r_rdv1 <= 1'b0;
    end else begin
      r_rdv0 <= w_grant[M0] & m0_read & ~m0_write;
      r_rdv1 <= w_grant[M1] & m1_read & ~m1_write;
    end
  end

  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = r_rdv0;
  assign m1_readdatavalid = r_rdv1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (clear_start) begin
          w_state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        if (r_cnt == c_LAST_ADDR) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign clear_busy = (r_state == CLEAR);
  assign clear_done = r_done;

endmodule

`default_nettype wire
